bfifo_reader: RTL

//  Read-side controller for the button-pulse FIFO (bfifo). Drains stored words by

---
 rtl/bfifo_pkg.sv | 22 ++
 rtl/bfifo_reader_if.sv | 22 ++
 rtl/bfifo.sv | 58 +++++
 rtl/bfifo_reader_rd_pulse_gen.sv | 48 ++++
 rtl/bfifo_reader.sv | 92 +++++++++
 5 files changed

// File: rtl/bfifo_pkg.sv
// Shared definitions for the bfifo read side: reader FSM states and bfifo read timing.
// bfifo acts on the falling edge of rd, BFIFO_RD_LAT edges later.
package bfifo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    SETTLE  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam int BFIFO_RD_LAT = 2;
  localparam int SETTLE_MIN   = BFIFO_RD_LAT + 1;

  // Bits needed to hold the largest timer reload (max(pulse_w, settle) - 1).
  function automatic int timer_width(input int pulse_w, input int settle);
    int m;
    m = (pulse_w > settle) ? pulse_w : settle;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bfifo_reader_if.sv
// Reader bus: bfifo read side (rd/dout/empty) plus the valid/ready output stream.
// master = bfifo_reader, slave = the bfifo/sink pair facing it.
interface bfifo_reader_if #(
  parameter int DBITS = 8
);
  logic             fifo_empty;
  logic [DBITS-1:0] fifo_dout;
  logic             fifo_rd;
  logic [DBITS-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_rd, out_data, out_valid
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_rd, out_data, out_valid
  );
endinterface

// File: rtl/bfifo.sv
// Button-pulse FIFO: wr/rd are level pulses, acted on at their falling edge two edges late.
// Registered dout updates on the read action; reads when empty and writes when full are ignored.
module bfifo #(
  parameter int abits = 3,
  parameter int dbits = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_wr,
  input  logic             i_rd,
  input  logic [dbits-1:0] i_wdata,
  output logic [dbits-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);
  logic [dbits-1:0] r_mem [2**abits];
  logic [abits:0]   r_wptr;
  logic [abits:0]   r_rptr;
  logic [dbits-1:0] r_rdata;
  logic             r_wr_s1, r_wr_s2;
  logic             r_rd_s1, r_rd_s2;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[abits] != r_rptr[abits]) &&
                   (r_wptr[abits-1:0] == r_rptr[abits-1:0]);
  assign w_do_wr = r_wr_s2 & ~r_wr_s1 & ~o_full;
  assign w_do_rd = r_rd_s2 & ~r_rd_s1 & ~o_empty;
  assign o_rdata = r_rdata;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_s1 <= 1'b0;
      r_wr_s2 <= 1'b0;
      r_rd_s1 <= 1'b0;
      r_rd_s2 <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_rdata <= '0;
    end else begin
      r_wr_s1 <= i_wr;
      r_wr_s2 <= r_wr_s1;
      r_rd_s1 <= i_rd;
      r_rd_s2 <= r_rd_s1;
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) begin
        r_rdata <= r_mem[r_rptr[abits-1:0]];
        r_rptr  <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_do_wr) r_mem[r_wptr[abits-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/bfifo_reader_rd_pulse_gen.sv
// Drives one registered rd pulse of pulse_w cycles, then times settle cycles for bfifo dout.
// o_pulse_last / o_done flag the final cycle of each phase; start is ignored while active.
module rd_pulse_gen
  import bfifo_pkg::*;
#(
  parameter int pulse_w = 1,
  parameter int settle  = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_rd,
  output logic o_pulse_last,
  output logic o_done
);
  localparam int TW = timer_width(pulse_w, settle);

  logic          r_active;
  logic          r_rd;
  logic [TW-1:0] r_timer;

  assign o_rd         = r_rd;
  assign o_pulse_last = r_rd & (r_timer == '0);
  assign o_done       = r_active & ~r_rd & (r_timer == '0);

  // One down-counter serves both phases; r_rd tells them apart.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_rd     <= 1'b0;
      r_timer  <= '0;
    end else if (i_start && !r_active) begin
      r_active <= 1'b1;
      r_rd     <= 1'b1;
      r_timer  <= TW'(pulse_w - 1);
    end else if (r_active) begin
      if (r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end else if (r_rd) begin
        r_rd    <= 1'b0;
        r_timer <= TW'(settle - 1);
      end else begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bfifo_reader.sv
// Drains bfifo one word at a time onto a valid/ready stream; out_valid rises pulse_w+settle edges after the read starts.
// A stalled sink holds the word in PRESENT and blocks further reads; all outputs registered.
module bfifo_reader
  import bfifo_pkg::*;
#(
  parameter int dbits   = 8,
  parameter int pulse_w = 1,
  parameter int settle  = 3,
  parameter int cbits   = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  bfifo_reader_if.master   bus,
  output logic             o_busy,
  output logic [cbits-1:0] o_drained
);
  generate
    if (settle < SETTLE_MIN) begin : g_bad_settle
      $error("bfifo_reader: settle must be at least SETTLE_MIN");
    end
    if (pulse_w < 1) begin : g_bad_pulse
      $error("bfifo_reader: pulse_w must be at least 1");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start;
  logic             w_rd;
  logic             w_pulse_last;
  logic             w_done;
  logic [dbits-1:0] r_out_data;
  logic             r_out_valid;
  logic [cbits-1:0] r_drained;

  rd_pulse_gen #(
    .pulse_w (pulse_w),
    .settle  (settle)
  ) u_pulse (
    .i_clk        (i_clock),
    .i_rst        (i_reset),
    .i_start      (w_start),
    .o_rd         (w_rd),
    .o_pulse_last (w_pulse_last),
    .o_done       (w_done)
  );

  assign bus.fifo_rd   = w_rd;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign o_busy        = (r_state != IDLE);
  assign o_drained     = r_drained;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Returning to IDLE on the handshake gives bfifo's empty flag time to settle before re-sampling.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_enable && !bus.fifo_empty) begin
          w_state_nxt = PULSE;
          w_start     = 1'b1;
        end
      end
      PULSE:   if (w_pulse_last)  w_state_nxt = SETTLE;
      SETTLE:  if (w_done)        w_state_nxt = PRESENT;
      PRESENT: if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_drained   <= '0;
    end else if (r_state == SETTLE && w_done) begin
      r_out_data  <= bus.fifo_dout;
      r_out_valid <= 1'b1;
    end else if (r_state == PRESENT && r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_drained   <= r_drained + cbits'(1);
    end
  end

endmodule
